// File: rtl/jogo_pkg.sv
// Shared game constants: state encoding, coordinate widths and screen limits.
package jogo_pkg;

  localparam int unsigned COORD_W = 10;  // screen coordinate width
  localparam int unsigned EDGE_W  = 12;  // widened width for edge arithmetic
  localparam int unsigned IDX_W   = 8;   // cell index / count width

  localparam int unsigned TELA_MARGEM_ESQ = 20;
  localparam int unsigned TELA_LIM_DIR    = 640;
  localparam int unsigned TELA_LIM_INF    = 440;

  typedef enum logic [1:0] {
    MOVER    = 2'd0,
    LIMPO    = 2'd1,
    INVADIDO = 2'd2
  } estado_t;

endpackage

// File: rtl/borda_formacao.sv
// Reduces the alive mask to the leftmost/rightmost occupied column and the
// lowest occupied row. Outputs are combinational.
module borda_formacao
  import jogo_pkg::*;
#(
  parameter int unsigned COLS = 5,
  parameter int unsigned ROWS = 3
) (
  input  logic [ROWS*COLS-1:0] vivo_i,
  output logic [IDX_W-1:0]     cmin_c_o,
  output logic [IDX_W-1:0]     cmax_c_o,
  output logic [IDX_W-1:0]     rmax_c_o
);

  localparam int unsigned NCEL = ROWS * COLS;
  localparam int unsigned IW   = (NCEL > 1) ? $clog2(NCEL) : 1;

  logic achou;

  // Column-major scan: first occupied column is cmin, last is cmax.
  always_comb begin
    achou    = 1'b0;
    cmin_c_o = '0;
    cmax_c_o = '0;
    rmax_c_o = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        if (vivo_i[IW'(r * int'(COLS) + c)]) begin
          if (!achou) cmin_c_o = IDX_W'(c);
          achou    = 1'b1;
          cmax_c_o = IDX_W'(c);
          if (IDX_W'(r) > rmax_c_o) rmax_c_o = IDX_W'(r);
        end
      end
    end
  end

endmodule

// File: rtl/formacao_inimigos.sv
// Enemy formation: sideways march with descent on bounce, shot hit detection,
// cleared / invaded end states. Optional FORMACAO_ACELERA_EN doubles the step
// once at most one row's worth of enemies remain.
module formacao_inimigos
  import jogo_pkg::*;
#(
  parameter int unsigned COLS       = 5,
  parameter int unsigned ROWS       = 3,
  parameter int unsigned X_INI      = 100,
  parameter int unsigned Y_INI      = 90,
  parameter int unsigned PASSO_X    = 100,
  parameter int unsigned PASSO_Y    = 40,
  parameter int unsigned LARG       = 33,
  parameter int unsigned ALT        = 24,
  parameter int unsigned VEL        = 2,
  parameter int unsigned DESCIDA    = 10,
  parameter int unsigned MARGEM_ESQ = TELA_MARGEM_ESQ,
  parameter int unsigned LIM_DIR    = TELA_LIM_DIR,
  parameter int unsigned LIM_INF    = TELA_LIM_INF
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 reiniciarJogo,
  input  logic                 pausa,
  input  logic                 tick_mv,
  input  logic [COORD_W-1:0]   bola_nave_x,
  input  logic [COORD_W-1:0]   bola_nave_y,
  input  logic                 bola_valida,
  output logic [COORD_W-1:0]   form_x,
  output logic [COORD_W-1:0]   form_y,
  output logic [ROWS*COLS-1:0] vivo,
  output logic [IDX_W-1:0]     restantes,
  output logic                 acerto,
  output logic [IDX_W-1:0]     acerto_idx,
  output logic                 limpo,
  output logic                 invadiu
);

  localparam int unsigned NCEL = ROWS * COLS;
  localparam int unsigned IW   = (NCEL > 1) ? $clog2(NCEL) : 1;

  estado_t             state_q, state_d;
  logic [COORD_W-1:0]  form_x_q, form_x_d;
  logic [COORD_W-1:0]  form_y_q, form_y_d;
  logic                sentido_q, sentido_d;
  logic [NCEL-1:0]     vivo_q, vivo_d;
  logic [IDX_W-1:0]    restantes_q, restantes_d;
  logic                acerto_q, acerto_d;
  logic [IDX_W-1:0]    acerto_idx_q, acerto_idx_d;
  logic                limpo_q, limpo_d;
  logic                invadiu_q, invadiu_d;

  logic [IDX_W-1:0]    cmin_c, cmax_c, rmax_c;
  logic [EDGE_W-1:0]   step_c;
  logic                hit_c;
  logic [IDX_W-1:0]    hit_idx_c;
  logic [NCEL-1:0]     hit_mask_c;
  logic [EDGE_W-1:0]   ex_c, ey_c, bx_c, by_c;
  logic                borda_dir_c, borda_esq_c, fundo_c;
  logic [EDGE_W-1:0]   y_desc_c;
  logic                desce_c;

  borda_formacao #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_borda (
    .vivo_i   (vivo_q),
    .cmin_c_o (cmin_c),
    .cmax_c_o (cmax_c),
    .rmax_c_o (rmax_c)
  );

`ifdef FORMACAO_ACELERA_EN
  // Faster march once the survivors fit in a single row.
  assign step_c = (restantes_q <= IDX_W'(COLS)) ? EDGE_W'(2 * VEL) : EDGE_W'(VEL);
`else
  assign step_c = EDGE_W'(VEL);
`endif

  assign bx_c = EDGE_W'(bola_nave_x);
  assign by_c = EDGE_W'(bola_nave_y);

  // Lowest-index alive cell whose box contains the shot point (pre-move origin).
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    hit_mask_c = '0;
    ex_c       = '0;
    ey_c       = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        ex_c = EDGE_W'(form_x_q) + EDGE_W'(c * int'(PASSO_X));
        ey_c = EDGE_W'(form_y_q) + EDGE_W'(r * int'(PASSO_Y));
        if (!hit_c && vivo_q[IW'(r * int'(COLS) + c)] &&
            (bx_c >= ex_c) && (bx_c < ex_c + EDGE_W'(LARG)) &&
            (by_c >= ey_c) && (by_c < ey_c + EDGE_W'(ALT))) begin
          hit_c      = 1'b1;
          hit_idx_c  = IDX_W'(r * int'(COLS) + c);
          hit_mask_c[IW'(r * int'(COLS) + c)] = 1'b1;
        end
      end
    end
  end

  // Edge and floor tests on the pre-hit mask. The origin is unsigned, so a
  // left step that would take it below zero also counts as reaching the edge.
  always_comb begin
    borda_dir_c = (EDGE_W'(form_x_q) + EDGE_W'(32'(cmax_c) * PASSO_X) +
                   EDGE_W'(LARG) + step_c) > EDGE_W'(LIM_DIR);
    borda_esq_c = ((EDGE_W'(form_x_q) + EDGE_W'(32'(cmin_c) * PASSO_X)) <
                   (EDGE_W'(MARGEM_ESQ) + step_c)) ||
                  (EDGE_W'(form_x_q) < step_c);
    y_desc_c    = EDGE_W'(form_y_q) + EDGE_W'(DESCIDA);
    fundo_c     = (y_desc_c + EDGE_W'(32'(rmax_c) * PASSO_Y) + EDGE_W'(ALT)) >=
                  EDGE_W'(LIM_INF);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    form_x_d     = form_x_q;
    form_y_d     = form_y_q;
    sentido_d    = sentido_q;
    vivo_d       = vivo_q;
    restantes_d  = restantes_q;
    acerto_d     = 1'b0;
    acerto_idx_d = '0;
    limpo_d      = limpo_q;
    invadiu_d    = invadiu_q;
    desce_c      = 1'b0;

    case (state_q)
      MOVER: begin
        if (!pausa) begin
          if (bola_valida && hit_c) begin
            vivo_d       = vivo_q & ~hit_mask_c;
            restantes_d  = restantes_q - IDX_W'(1);
            acerto_d     = 1'b1;
            acerto_idx_d = hit_idx_c;
          end
          if (tick_mv) begin
            if (!sentido_q) begin
              if (borda_dir_c) begin
                form_y_d  = COORD_W'(y_desc_c);
                sentido_d = 1'b1;
                desce_c   = 1'b1;
              end else begin
                form_x_d  = COORD_W'(EDGE_W'(form_x_q) + step_c);
              end
            end else begin
              if (borda_esq_c) begin
                form_y_d  = COORD_W'(y_desc_c);
                sentido_d = 1'b0;
                desce_c   = 1'b1;
              end else begin
                form_x_d  = COORD_W'(EDGE_W'(form_x_q) - step_c);
              end
            end
          end
          if (bola_valida && hit_c && (restantes_q == IDX_W'(1))) begin
            state_d = LIMPO;
            limpo_d = 1'b1;
          end else if (desce_c && fundo_c) begin
            state_d   = INVADIDO;
            invadiu_d = 1'b1;
          end
        end
      end
      LIMPO, INVADIDO: begin
        state_d = state_q;
      end
      default: begin
        state_d = MOVER;
      end
    endcase
  end

  // State and output registers; reset and restart are equivalent.
  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      state_q      <= MOVER;
      form_x_q     <= COORD_W'(X_INI);
      form_y_q     <= COORD_W'(Y_INI);
      sentido_q    <= 1'b0;
      vivo_q       <= '1;
      restantes_q  <= IDX_W'(NCEL);
      acerto_q     <= 1'b0;
      acerto_idx_q <= '0;
      limpo_q      <= 1'b0;
      invadiu_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      form_x_q     <= form_x_d;
      form_y_q     <= form_y_d;
      sentido_q    <= sentido_d;
      vivo_q       <= vivo_d;
      restantes_q  <= restantes_d;
      acerto_q     <= acerto_d;
      acerto_idx_q <= acerto_idx_d;
      limpo_q      <= limpo_d;
      invadiu_q    <= invadiu_d;
    end
  end

  assign form_x     = form_x_q;
  assign form_y     = form_y_q;
  assign vivo       = vivo_q;
  assign restantes  = restantes_q;
  assign acerto     = acerto_q;
  assign acerto_idx = acerto_idx_q;
  assign limpo      = limpo_q;
  assign invadiu    = invadiu_q;

endmodule

// File: tb/tb_formacao_inimigos.sv
// Directed bench for formacao_inimigos with hand-computed expectations.
// Honors FORMACAO_ACELERA_EN when computing the expected accelerated step.
module tb_formacao_inimigos;

  logic        clk;
  logic        reset;
  logic        reiniciarJogo;
  logic        pausa;
  logic        tick_mv;
  logic [9:0]  bola_nave_x;
  logic [9:0]  bola_nave_y;
  logic        bola_valida;
  logic [9:0]  form_x;
  logic [9:0]  form_y;
  logic [14:0] vivo;
  logic [7:0]  restantes;
  logic        acerto;
  logic [7:0]  acerto_idx;
  logic        limpo;
  logic        invadiu;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned step_exp;
  int unsigned fx_exp;

  formacao_inimigos dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .reiniciarJogo (reiniciarJogo),
    .pausa         (pausa),
    .tick_mv       (tick_mv),
    .bola_nave_x   (bola_nave_x),
    .bola_nave_y   (bola_nave_y),
    .bola_valida   (bola_valida),
    .form_x        (form_x),
    .form_y        (form_y),
    .vivo          (vivo),
    .restantes     (restantes),
    .acerto        (acerto),
    .acerto_idx    (acerto_idx),
    .limpo         (limpo),
    .invadiu       (invadiu)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic tick_once();
    tick_mv = 1'b1;
    step();
    tick_mv = 1'b0;
    step();
  endtask

  task automatic shot_once(input int unsigned x, input int unsigned y);
    bola_nave_x = 10'(x);
    bola_nave_y = 10'(y);
    bola_valida = 1'b1;
    step();
    bola_valida = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reiniciarJogo = 1'b0; pausa = 1'b0; tick_mv = 1'b0;
    bola_nave_x = '0; bola_nave_y = '0; bola_valida = 1'b0;
`ifdef FORMACAO_ACELERA_EN
    step_exp = 4;
`else
    step_exp = 2;
`endif

    // Reset values
    step(); step();
    reset = 1'b0;
    chk("rst_form_x", 32'(form_x), 100);
    chk("rst_form_y", 32'(form_y), 90);
    chk("rst_vivo", 32'(vivo), 32'h7fff);
    chk("rst_restantes", 32'(restantes), 15);
    chk("rst_acerto", 32'(acerto), 0);
    chk("rst_limpo", 32'(limpo), 0);
    chk("rst_invadiu", 32'(invadiu), 0);

    // March right and first bounce
    for (int i = 0; i < 53; i++) tick_once();
    chk("mv53_form_x", 32'(form_x), 206);
    chk("mv53_form_y", 32'(form_y), 90);
    tick_once();
    chk("bounce_form_x", 32'(form_x), 206);
    chk("bounce_form_y", 32'(form_y), 100);
    tick_once();
    chk("left_form_x", 32'(form_x), 204);

    // Single hit, then held shot gives no second hit
    do_reset();
    bola_nave_x = 10'd110; bola_nave_y = 10'd100; bola_valida = 1'b1;
    step();
    chk("hit_acerto", 32'(acerto), 1);
    chk("hit_idx", 32'(acerto_idx), 0);
    chk("hit_vivo", 32'(vivo), 32'h7ffe);
    chk("hit_restantes", 32'(restantes), 14);
    step();
    bola_valida = 1'b0;
    chk("held_acerto", 32'(acerto), 0);
    chk("held_restantes", 32'(restantes), 14);

    // Tick and hit together: hit uses pre-move origin
    do_reset();
    bola_nave_x = 10'd101; bola_nave_y = 10'd91; bola_valida = 1'b1; tick_mv = 1'b1;
    step();
    bola_valida = 1'b0; tick_mv = 1'b0;
    chk("coinc_acerto", 32'(acerto), 1);
    chk("coinc_form_x", 32'(form_x), 102);
    chk("coinc_vivo", 32'(vivo), 32'h7ffe);

    // Hit on a non-zero index (row 1, column 2)
    do_reset();
    shot_once(301, 131);
    chk("idx7_acerto_idx", 32'(acerto_idx), 7);
    chk("idx7_vivo", 32'(vivo), 32'h7f7f);

    // Column 4 cleared moves the right bounce to form_x=306
    do_reset();
    for (int r = 0; r < 3; r++) shot_once(501, 91 + r * 40);
    chk("col4_vivo", 32'(vivo), 32'h3def);
    chk("col4_restantes", 32'(restantes), 12);
    for (int i = 0; i < 103; i++) tick_once();
    chk("col4_pre_form_x", 32'(form_x), 306);
    chk("col4_pre_form_y", 32'(form_y), 90);
    tick_once();
    chk("col4_bounce_x", 32'(form_x), 306);
    chk("col4_bounce_y", 32'(form_y), 100);

    // Pause freezes ticks and shots; nothing queued
    do_reset();
    pausa = 1'b1;
    for (int i = 0; i < 10; i++) tick_once();
    shot_once(110, 100);
    chk("pause_acerto", 32'(acerto), 0);
    pausa = 1'b0;
    step();
    chk("pause_form_x", 32'(form_x), 100);
    chk("pause_vivo", 32'(vivo), 32'h7fff);
    chk("pause_restantes", 32'(restantes), 15);

    // Invasion after 25 descents
    do_reset();
    for (int i = 0; i < 20000 && !invadiu; i++) tick_once();
    chk("inv_flag", 32'(invadiu), 1);
    chk("inv_form_y", 32'(form_y), 340);
    fx_exp = 32'(form_x);
    for (int i = 0; i < 5; i++) tick_once();
    shot_once(32'(form_x) + 1, 32'(form_y) + 1);
    chk("inv_frozen_y", 32'(form_y), 340);
    chk("inv_frozen_x", 32'(form_x), fx_exp);
    chk("inv_frozen_rest", 32'(restantes), 15);
    chk("inv_limpo", 32'(limpo), 0);
    reiniciarJogo = 1'b1;
    step();
    reiniciarJogo = 1'b0;
    chk("restart_form_x", 32'(form_x), 100);
    chk("restart_form_y", 32'(form_y), 90);
    chk("restart_invadiu", 32'(invadiu), 0);
    chk("restart_vivo", 32'(vivo), 32'h7fff);
    tick_once();
    chk("restart_moves_right", 32'(form_x), 102);

    // Destroy everything; check the step once 5 remain
    do_reset();
    for (int i = 0; i < 10; i++) shot_once(101 + (i % 5) * 100, 91 + (i / 5) * 40);
    chk("kill10_restantes", 32'(restantes), 5);
    chk("kill10_vivo", 32'(vivo), 32'h7c00);
    tick_once();
    fx_exp = 100 + step_exp;
    chk("accel_form_x", 32'(form_x), fx_exp);
    for (int c = 0; c < 5; c++) shot_once(fx_exp + 1 + c * 100, 171);
    chk("clear_limpo", 32'(limpo), 1);
    chk("clear_restantes", 32'(restantes), 0);
    chk("clear_vivo", 32'(vivo), 0);
    tick_once();
    chk("clear_frozen_x", 32'(form_x), fx_exp);

    // Reset leaves the cleared state
    do_reset();
    chk("clr_rst_limpo", 32'(limpo), 0);
    chk("clr_rst_restantes", 32'(restantes), 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
